// File: rtl/track_controller.sv
// Sequencing controller for the template-matching tracker: owns the target centre and box.
// Optional macro TRACK_SMOOTH_EN averages the old centre with each accepted match.
module track_controller #(
   parameter int VGA_WIDTH      = 640,
   parameter int VGA_HEIGHT     = 480,
   parameter int HALF_BOX       = 16,
   parameter int MAX_STEP       = 40,
   parameter int MISS_LIMIT     = 4,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_track,
   input  logic        stop_track,
   input  logic [9:0]  init_x,
   input  logic [9:0]  init_y,
   input  logic        template_done,
   input  logic        frame_rdy,
   input  logic        max_ready,
   input  logic [9:0]  max_x,
   input  logic [9:0]  max_y,
   output logic        template_load,
   output logic        tracking_mode,
   output logic [9:0]  c_x,
   output logic [9:0]  c_y,
   output logic [9:0]  left,
   output logic [9:0]  right,
   output logic [9:0]  top,
   output logic [9:0]  bottom,
   output logic [15:0] frame_count,
   output logic        lost,
   output logic        busy
);

   localparam int MW = $clog2(MISS_LIMIT + 1);
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [9:0] RESET_X = 10'(VGA_WIDTH / 2);
   localparam logic [9:0] RESET_Y = 10'(VGA_HEIGHT / 2);

   typedef enum logic [2:0] {IDLE, CAPTURE, ARM, SEARCH, UPDATE} state_t;

   state_t          state_q, state_d;
   logic [9:0]      cx_q, cx_d, cy_q, cy_d;
   logic [9:0]      mx_q, mx_d, my_q, my_d;
   logic [9:0]      left_q, left_d, right_q, right_d, top_q, top_d, bottom_q, bottom_d;
   logic [15:0]     frame_count_q, frame_count_d;
   logic [MW-1:0]   miss_q, miss_d;
   logic [TW-1:0]   timeout_q, timeout_d;
   logic            lost_q, lost_d;
   logic            tmpl_load_q, tmpl_load_d;
   logic            track_q, track_d;
   logic            busy_q, busy_d;
   logic            frame_rdy_q, max_ready_q;
   logic            frameEdge, maxEdge;
   logic [10:0]     dx, dy, sumX, sumY;

   function automatic logic [9:0] clampCoord(input logic [9:0] v, input int lim);
      return (v > 10'(lim - 1)) ? 10'(lim - 1) : v;
   endfunction

   function automatic logic [9:0] boxLow(input logic [9:0] c);
      logic signed [10:0] t;
      t = $signed({1'b0, c}) - $signed(11'(HALF_BOX));
      return (t < 0) ? 10'd0 : t[9:0];
   endfunction

   function automatic logic [9:0] boxHigh(input logic [9:0] c, input int lim);
      logic signed [10:0] t;
      t = $signed({1'b0, c}) + $signed(11'(HALF_BOX));
      return (t > $signed(11'(lim - 1))) ? 10'(lim - 1) : t[9:0];
   endfunction

   assign frameEdge = frame_rdy & ~frame_rdy_q;
   assign maxEdge   = max_ready & ~max_ready_q;

   assign dx   = (mx_q >= cx_q) ? ({1'b0, mx_q} - {1'b0, cx_q}) : ({1'b0, cx_q} - {1'b0, mx_q});
   assign dy   = (my_q >= cy_q) ? ({1'b0, my_q} - {1'b0, cy_q}) : ({1'b0, cy_q} - {1'b0, my_q});
   assign sumX = {1'b0, cx_q} + {1'b0, mx_q};
   assign sumY = {1'b0, cy_q} + {1'b0, my_q};

   // Next-state and next-output logic; stop_track overrides everything and freezes the data path.
   always_comb begin
      state_d       = state_q;
      cx_d          = cx_q;
      cy_d          = cy_q;
      mx_d          = mx_q;
      my_d          = my_q;
      frame_count_d = frame_count_q;
      miss_d        = miss_q;
      timeout_d     = timeout_q;
      lost_d        = lost_q;
      tmpl_load_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_track) begin
               cx_d        = clampCoord(init_x, VGA_WIDTH);
               cy_d        = clampCoord(init_y, VGA_HEIGHT);
               lost_d      = 1'b0;
               miss_d      = '0;
               tmpl_load_d = 1'b1;
               state_d     = CAPTURE;
            end
         end
         CAPTURE: begin
            if (template_done) state_d = ARM;
         end
         ARM: begin
            if (frameEdge) begin
               timeout_d = '0;
               state_d   = SEARCH;
            end
         end
         SEARCH: begin
            if (maxEdge) begin
               mx_d    = clampCoord(max_x, VGA_WIDTH);
               my_d    = clampCoord(max_y, VGA_HEIGHT);
               state_d = UPDATE;
            end else if (timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
               miss_d = miss_q + 1'b1;
               if (miss_d >= MW'(MISS_LIMIT)) begin
                  lost_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = ARM;
               end
            end else begin
               timeout_d = timeout_q + 1'b1;
            end
         end
         UPDATE: begin
            if (dx > 11'(MAX_STEP) || dy > 11'(MAX_STEP)) begin
               miss_d = miss_q + 1'b1;
            end else begin
`ifdef TRACK_SMOOTH_EN
               cx_d = sumX[10:1];
               cy_d = sumY[10:1];
`else
               cx_d = mx_q;
               cy_d = my_q;
`endif
               miss_d        = '0;
               frame_count_d = frame_count_q + 16'd1;
            end
            if (miss_d >= MW'(MISS_LIMIT)) begin
               lost_d  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = ARM;
            end
         end
         default: state_d = IDLE;
      endcase

      if (stop_track) begin
         state_d       = IDLE;
         cx_d          = cx_q;
         cy_d          = cy_q;
         mx_d          = mx_q;
         my_d          = my_q;
         frame_count_d = frame_count_q;
         miss_d        = miss_q;
         timeout_d     = timeout_q;
         lost_d        = lost_q;
         tmpl_load_d   = 1'b0;
      end

      track_d  = (state_d == ARM) || (state_d == SEARCH) || (state_d == UPDATE);
      busy_d   = (state_d != IDLE);
      left_d   = boxLow(cx_q);
      right_d  = boxHigh(cx_q, VGA_WIDTH);
      top_d    = boxLow(cy_q);
      bottom_d = boxHigh(cy_q, VGA_HEIGHT);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cx_q          <= RESET_X;
         cy_q          <= RESET_Y;
         mx_q          <= '0;
         my_q          <= '0;
         left_q        <= boxLow(RESET_X);
         right_q       <= boxHigh(RESET_X, VGA_WIDTH);
         top_q         <= boxLow(RESET_Y);
         bottom_q      <= boxHigh(RESET_Y, VGA_HEIGHT);
         frame_count_q <= '0;
         miss_q        <= '0;
         timeout_q     <= '0;
         lost_q        <= 1'b0;
         tmpl_load_q   <= 1'b0;
         track_q       <= 1'b0;
         busy_q        <= 1'b0;
         frame_rdy_q   <= 1'b0;
         max_ready_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cx_q          <= cx_d;
         cy_q          <= cy_d;
         mx_q          <= mx_d;
         my_q          <= my_d;
         left_q        <= left_d;
         right_q       <= right_d;
         top_q         <= top_d;
         bottom_q      <= bottom_d;
         frame_count_q <= frame_count_d;
         miss_q        <= miss_d;
         timeout_q     <= timeout_d;
         lost_q        <= lost_d;
         tmpl_load_q   <= tmpl_load_d;
         track_q       <= track_d;
         busy_q        <= busy_d;
         frame_rdy_q   <= frame_rdy;
         max_ready_q   <= max_ready;
      end
   end

   assign template_load = tmpl_load_q;
   assign tracking_mode = track_q;
   assign c_x           = cx_q;
   assign c_y           = cy_q;
   assign left          = left_q;
   assign right         = right_q;
   assign top           = top_q;
   assign bottom        = bottom_q;
   assign frame_count   = frame_count_q;
   assign lost          = lost_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_track_controller.sv
// Directed bench for track_controller with hand-computed expectations; TIMEOUT_CYCLES is 100 here.
module tb_track_controller;

   logic        clk = 1'b0;
   logic        rst, start_track, stop_track, template_done, frame_rdy, max_ready;
   logic [9:0]  init_x, init_y, max_x, max_y;
   logic        template_load, tracking_mode, lost, busy;
   logic [9:0]  c_x, c_y, left, right, top, bottom;
   logic [15:0] frame_count;

   int compareCount  = 0;
   int mismatchCount = 0;

   track_controller #(
      .VGA_WIDTH(640), .VGA_HEIGHT(480), .HALF_BOX(16), .MAX_STEP(40),
      .MISS_LIMIT(4), .TIMEOUT_CYCLES(100)
   ) dut (
      .clk(clk), .rst(rst), .start_track(start_track), .stop_track(stop_track),
      .init_x(init_x), .init_y(init_y), .template_done(template_done),
      .frame_rdy(frame_rdy), .max_ready(max_ready), .max_x(max_x), .max_y(max_y),
      .template_load(template_load), .tracking_mode(tracking_mode),
      .c_x(c_x), .c_y(c_y), .left(left), .right(right), .top(top), .bottom(bottom),
      .frame_count(frame_count), .lost(lost), .busy(busy)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compareCount++;
      if (observed != expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Start from IDLE with a given centre and walk through capture into ARM.
   task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y);
      init_x = x; init_y = y; start_track = 1'b1;
      tick();
      start_track = 1'b0;
      template_done = 1'b1;
      tick();
      template_done = 1'b0;
   endtask

   // One frame from ARM: frame edge, then a correlator result, then the UPDATE cycle.
   task automatic runFrame(input logic [9:0] mx, input logic [9:0] my);
      frame_rdy = 1'b1;
      tick();
      frame_rdy = 1'b0;
      max_x = mx; max_y = my; max_ready = 1'b1;
      tick();
      max_ready = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; start_track = 1'b0; stop_track = 1'b0; template_done = 1'b0;
      frame_rdy = 1'b0; max_ready = 1'b0;
      init_x = '0; init_y = '0; max_x = '0; max_y = '0;
      tick(); tick();

      checkOutput("rst_cx", c_x, 320);
      checkOutput("rst_cy", c_y, 240);
      checkOutput("rst_left", left, 304);
      checkOutput("rst_right", right, 336);
      checkOutput("rst_top", top, 224);
      checkOutput("rst_bottom", bottom, 256);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_mode", tracking_mode, 0);
      checkOutput("rst_fc", frame_count, 0);
      rst = 1'b0;
      tick();

      // Start with (100,50): single template_load pulse, centre latched.
      init_x = 10'd100; init_y = 10'd50; start_track = 1'b1;
      tick();
      start_track = 1'b0;
      checkOutput("tl_pulse", template_load, 1);
      checkOutput("start_cx", c_x, 100);
      checkOutput("start_cy", c_y, 50);
      checkOutput("cap_busy", busy, 1);
      checkOutput("cap_mode", tracking_mode, 0);
      tick();
      checkOutput("tl_drop", template_load, 0);
      checkOutput("box_l", left, 84);
      checkOutput("box_r", right, 116);
      checkOutput("box_t", top, 34);
      checkOutput("box_b", bottom, 66);
      template_done = 1'b1;
      tick();
      template_done = 1'b0;
      checkOutput("arm_mode", tracking_mode, 1);

      // Accepted update to (120,60); two edges after the max_ready edge.
      frame_rdy = 1'b1;
      tick();
      frame_rdy = 1'b0;
      max_x = 10'd120; max_y = 10'd60; max_ready = 1'b1;
      tick();
      max_ready = 1'b0;
      checkOutput("upd_cx_early", c_x, 100);
      tick();
`ifdef TRACK_SMOOTH_EN
      checkOutput("upd_cx", c_x, 110);
      checkOutput("upd_cy", c_y, 55);
`else
      checkOutput("upd_cx", c_x, 120);
      checkOutput("upd_cy", c_y, 60);
`endif
      checkOutput("upd_fc", frame_count, 1);

      // Restart at (100,50) and lose the target with four far matches.
      stop_track = 1'b1;
      tick();
      stop_track = 1'b0;
      checkOutput("stop_mode", tracking_mode, 0);
      applyStimulus(10'd100, 10'd50);
      for (int i = 0; i < 3; i++) runFrame(10'd300, 10'd300);
      checkOutput("miss3_lost", lost, 0);
      checkOutput("miss3_mode", tracking_mode, 1);
      runFrame(10'd300, 10'd300);
      checkOutput("lost_flag", lost, 1);
      checkOutput("lost_mode", tracking_mode, 0);
      checkOutput("lost_busy", busy, 0);
      checkOutput("lost_cx", c_x, 100);
      checkOutput("lost_cy", c_y, 50);
      checkOutput("lost_fc", frame_count, 1);

      // Timeout: SEARCH entered at edge E0, ARM again at E100; a late max_ready is ignored.
      applyStimulus(10'd200, 10'd200);
      checkOutput("restart_lost", lost, 0);
      frame_rdy = 1'b1;
      tick();
      frame_rdy = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      max_x = 10'd210; max_y = 10'd205; max_ready = 1'b1;
      tick();
      max_ready = 1'b0;
      tick(); tick();
      checkOutput("to_ignored_cx", c_x, 200);
      checkOutput("to_mode", tracking_mode, 1);
      for (int i = 0; i < 3; i++) runFrame(10'd600, 10'd400);
      checkOutput("to_miss_lost", lost, 1);

      // Just before the timeout a max_ready edge at E99 still lands.
      applyStimulus(10'd200, 10'd200);
      frame_rdy = 1'b1;
      tick();
      frame_rdy = 1'b0;
      for (int i = 0; i < 98; i++) tick();
      max_x = 10'd210; max_y = 10'd205; max_ready = 1'b1;
      tick();
      max_ready = 1'b0;
      tick();
`ifdef TRACK_SMOOTH_EN
      checkOutput("e99_cx", c_x, 205);
`else
      checkOutput("e99_cx", c_x, 210);
`endif
      checkOutput("e99_fc", frame_count, 2);

      // stop_track together with a max_ready edge in SEARCH.
      frame_rdy = 1'b1;
      tick();
      frame_rdy = 1'b0;
      max_x = 10'd220; max_y = 10'd215; max_ready = 1'b1; stop_track = 1'b1;
      tick();
      max_ready = 1'b0; stop_track = 1'b0;
      checkOutput("stopsrch_mode", tracking_mode, 0);
      checkOutput("stopsrch_busy", busy, 0);
      tick();
`ifdef TRACK_SMOOTH_EN
      checkOutput("stopsrch_cx", c_x, 205);
`else
      checkOutput("stopsrch_cx", c_x, 210);
`endif
      checkOutput("stopsrch_fc", frame_count, 2);

      // Box corner clamping at (10,5), then out-of-range init clamping.
      init_x = 10'd10; init_y = 10'd5; start_track = 1'b1;
      tick();
      start_track = 1'b0;
      tick();
      checkOutput("corner_l", left, 0);
      checkOutput("corner_t", top, 0);
      checkOutput("corner_r", right, 26);
      checkOutput("corner_b", bottom, 21);
      stop_track = 1'b1;
      tick();
      stop_track = 1'b0;
      init_x = 10'd1000; init_y = 10'd700; start_track = 1'b1;
      tick();
      start_track = 1'b0;
      checkOutput("clamp_cx", c_x, 639);
      checkOutput("clamp_cy", c_y, 479);
      tick();
      checkOutput("clamp_l", left, 623);
      checkOutput("clamp_r", right, 639);
      checkOutput("clamp_b", bottom, 479);

      // Reset mid-operation restores the reset outputs.
      template_done = 1'b1;
      tick();
      template_done = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mid_rst_cx", c_x, 320);
      checkOutput("mid_rst_mode", tracking_mode, 0);
      checkOutput("mid_rst_busy", busy, 0);
      checkOutput("mid_rst_fc", frame_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
